// File: rtl/bus_timer.sv
// bus_timer: memory-mapped prescaled auto-reload timer with sticky update flag and level irq.
module bus_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        busWe,
    input  logic [31:0] busAddr,
    input  logic [31:0] busWData,
    output logic [31:0] busRData,
    output logic        irq
);
    logic        en, ie, uif;
    logic [31:0] psc, arr, cnt, pcnt;
    logic        sel, wr, clr, tick, wrap, w1c;
    logic [2:0]  off;
    always_comb begin
        sel  = busAddr[31:5] == BASE_ADDR[31:5];
        off  = busAddr[4:2];
        wr   = busWe & sel;
        clr  = wr & (off == 3'd0) & busWData[1];
        w1c  = wr & (off == 3'd4) & busWData[0];
        tick = en & (pcnt >= psc);
        wrap = tick & (cnt >= arr) & ~clr;
        irq  = uif & ie;
        busRData = !sel          ? 32'd0 :
                   off == 3'd0   ? {29'd0, ie, 1'b0, en} :
                   off == 3'd1   ? psc :
                   off == 3'd2   ? arr :
                   off == 3'd3   ? cnt :
                   off == 3'd4   ? {31'd0, uif} : 32'd0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en   <= 1'b0;
            ie   <= 1'b0;
            uif  <= 1'b0;
            psc  <= 32'd0;
            arr  <= 32'd0;
            cnt  <= 32'd0;
            pcnt <= 32'd0;
        end else begin
            if (wr && off == 3'd0) begin
                en <= busWData[0];
                ie <= busWData[2];
            end
            if (wr && off == 3'd1) psc <= busWData;
            if (wr && off == 3'd2) arr <= busWData;
            // CLR wins over any tick landing on the same edge
            if (clr) begin
                pcnt <= 32'd0;
                cnt  <= 32'd0;
            end else if (en) begin
                pcnt <= tick ? 32'd0 : pcnt + 32'd1;
                if (tick) cnt <= (cnt >= arr) ? 32'd0 : cnt + 32'd1;
            end
            // a fresh update beats a simultaneous write-1-to-clear
            if (wrap) uif <= 1'b1;
            else if (w1c) uif <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: randomized scoreboard bench for bus_timer against a register-level reference model.
module tb_bus_timer;
    localparam logic [31:0] BASE = 32'h1000_0000;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        busWe = 1'b0;
    logic [31:0] busAddr = 32'd0;
    logic [31:0] busWData = 32'd0;
    logic [31:0] busRData;
    logic        irq;
    bus_timer #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .busWe(busWe), .busAddr(busAddr),
        .busWData(busWData), .busRData(busRData), .irq(irq)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [31:0] a;
        logic [31:0] rd;
        logic        irq;
    } exp_t;
    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;
    logic        m_en, m_ie, m_uif;
    logic [31:0] m_psc, m_arr, m_cnt, m_pcnt;
    function automatic void model_clear();
        m_en = 0; m_ie = 0; m_uif = 0;
        m_psc = 0; m_arr = 0; m_cnt = 0; m_pcnt = 0;
    endfunction
    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[31:5] != BASE[31:5]) return 32'd0;
        case (a[4:0] & 5'h1C)
            5'h00: return {29'd0, m_ie, 1'b0, m_en};
            5'h04: return m_psc;
            5'h08: return m_arr;
            5'h0C: return m_cnt;
            5'h10: return {31'd0, m_uif};
            default: return 32'd0;
        endcase
    endfunction
    function automatic logic wraps_now();
        return m_en && m_pcnt >= m_psc && m_cnt >= m_arr;
    endfunction
    // one clock edge of the timer as the register map describes it
    function automatic void model_step(input logic we, input logic [31:0] a, input logic [31:0] d);
        logic hit, clr, tick, set;
        logic [4:0] o;
        hit  = we && a[31:5] == BASE[31:5];
        o    = a[4:0] & 5'h1C;
        clr  = hit && o == 5'h00 && d[1];
        tick = m_en && m_pcnt >= m_psc;
        set  = tick && m_cnt >= m_arr && !clr;
        if (clr) begin
            m_pcnt = 0; m_cnt = 0;
        end else if (m_en) begin
            m_pcnt = tick ? 0 : m_pcnt + 1;
            if (tick) m_cnt = (m_cnt >= m_arr) ? 0 : m_cnt + 1;
        end
        if (set) m_uif = 1;
        else if (hit && o == 5'h10 && d[0]) m_uif = 0;
        if (hit && o == 5'h00) begin m_en = d[0]; m_ie = d[2]; end
        if (hit && o == 5'h04) m_psc = d;
        if (hit && o == 5'h08) m_arr = d;
    endfunction
    task automatic cyc(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        reset = r; busWe = we; busAddr = a; busWData = d;
        if (r) model_clear();
        q.push_back('{a, model_read(a), m_uif & m_ie});
        if (!r) model_step(we, a, d);
    endtask
    task automatic wr(input logic [4:0] o, input logic [31:0] d);
        cyc(0, 1, BASE | 32'(o), d);
    endtask
    task automatic rd(input logic [4:0] o);
        cyc(0, 0, BASE | 32'(o), 32'hDEAD_BEEF);
    endtask
    task automatic wait_cnt(input logic [31:0] v);
        int n = 0;
        while (m_cnt != v && n < 100) begin rd(5'h0C); n++; end
        vectors++;
        if (m_cnt != v) begin
            miscompares++;
            $display("FAIL wait_cnt: model cnt %0d never reached required %0d", m_cnt, v);
        end
    endtask
    task automatic wait_wrap();
        int n = 0;
        while (!wraps_now() && n < 100) begin rd(5'h10); n++; end
        vectors++;
        if (!wraps_now()) begin
            miscompares++;
            $display("FAIL wait_wrap: no wrap cycle within 100 cycles");
        end
    endtask
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            vectors += 2;
            if (busRData !== e.rd) begin
                miscompares++;
                $display("FAIL rdata @%h: got %h expected %h (t=%0t)", e.a, busRData, e.rd, $time);
            end
            if (irq !== e.irq) begin
                miscompares++;
                $display("FAIL irq @%h: got %b expected %b (t=%0t)", e.a, irq, e.irq, $time);
            end
        end
    end
    initial begin
        model_clear();
        for (int i = 0; i < 8; i++) cyc(1, 0, BASE | 32'(i * 4), 0);
        cyc(1, 0, 32'h2000_0000, 0);
        for (int i = 0; i < 8; i++) rd(5'(i * 4));
        cyc(0, 0, BASE + 32'h20, 0);
        // PSC=0 ARR=3 with interrupts
        wr(5'h04, 0); wr(5'h08, 3); wr(5'h00, 32'h5);
        for (int i = 0; i < 12; i++) rd(i % 2 ? 5'h10 : 5'h0C);
        // PSC=2 ARR=1 without interrupts, then clear the flag
        wr(5'h00, 32'h2); wr(5'h10, 1); wr(5'h04, 2); wr(5'h08, 1); wr(5'h00, 32'h1);
        for (int i = 0; i < 10; i++) rd(i % 3 ? 5'h0C : 5'h10);
        wr(5'h10, 1); rd(5'h10);
        // lowering ARR below CNT
        wr(5'h04, 0); wr(5'h08, 9); wr(5'h00, 32'h7); wr(5'h10, 1);
        wait_cnt(5);
        wr(5'h08, 2);
        for (int i = 0; i < 4; i++) rd(i % 2 ? 5'h10 : 5'h0C);
        // W1C racing a set, then CLR racing a wrap
        wr(5'h08, 3); wr(5'h00, 32'h7); wr(5'h10, 1);
        wait_wrap();
        wr(5'h10, 1); rd(5'h10); wr(5'h10, 1);
        wait_wrap();
        wr(5'h00, 32'h3); rd(5'h0C); rd(5'h10);
        // read-only and reserved offsets
        wr(5'h0C, 32'h1234); rd(5'h0C);
        wr(5'h14, 32'hFFFF_FFFF); rd(5'h14);
        cyc(0, 1, 32'h2000_0004, 32'h55); rd(5'h04);
        // reset mid-count
        for (int i = 0; i < 5; i++) cyc(1, 0, BASE | 32'(i * 4), 0);
        for (int i = 0; i < 3; i++) rd(5'h0C);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] o;
            logic [31:0] a, d;
            logic we;
            o  = 5'($urandom_range(0, 7) * 4);
            a  = ($urandom_range(0, 15) == 0) ? (32'h3000_0000 | 32'(o)) : (BASE | 32'(o));
            we = $urandom_range(0, 3) == 0;
            d  = (o == 5'h04 || o == 5'h08) ? 32'($urandom_range(0, 5)) :
                 (o == 5'h00) ? (32'($urandom_range(0, 7)) & (($urandom_range(0, 7) == 0) ? 32'h7 : 32'h5)) :
                 $urandom;
            cyc($urandom_range(0, 499) == 0, we, a, d);
        end
        cyc(0, 0, BASE, 0);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected responses left unchecked, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
